bc: RTL

//   Control block (BC) for the polynomial datapath bo: a Moore FSM that drives
//   bo's load enables, mux selects and ULA op so that bo computes
//   S = a*x^2 + b*x + c by Horner's rule, S = (a*x + b)*x + c.

---
 rtl/bc.sv | 48 ++++
 1 files changed

// File: rtl/bc.sv
// bc: Moore control FSM that sequences bo through Horner evaluation
// S = (a*x + b)*x + c, with a start/busy/done handshake.
module bc #(
   parameter logic H_ADD = 1'b0,
   parameter logic H_MUL = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   output logic       LX,
   output logic [1:0] M0,
   output logic [1:0] M1,
   output logic [1:0] M2,
   output logic       H,
   output logic       LS,
   output logic       LH,
   output logic       busy,
   output logic       done
);
   typedef enum logic [2:0] {IDLE, LOAD, MUL_A, ADD_B, MUL_X, ADD_C, DONE} state_t;
   state_t state, state_nx;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   // Outputs depend on state only; unused encodings fall back to IDLE.
   always_comb begin
      state_nx = IDLE;
      LX       = 1'b0;
      M0       = 2'b00;
      M1       = 2'b00;
      M2       = 2'b00;
      H        = H_ADD;
      LS       = 1'b0;
      LH       = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE:  state_nx = start ? LOAD : IDLE;
         LOAD:  begin LX = 1'b1; state_nx = MUL_A; end
         MUL_A: begin H = H_MUL; LH = 1'b1; state_nx = ADD_B; end
         ADD_B: begin M0 = 2'b10; M1 = 2'b11; M2 = 2'b01; LS = 1'b1; state_nx = MUL_X; end
         MUL_X: begin M1 = 2'b10; H = H_MUL; LH = 1'b1; state_nx = ADD_C; end
         ADD_C: begin M0 = 2'b11; M1 = 2'b11; M2 = 2'b01; LS = 1'b1; state_nx = DONE; end
         DONE:  done = 1'b1;
         default: state_nx = IDLE;
      endcase
   end
   assign busy = (state != IDLE);
endmodule
